// File: rtl/layer_weight_loader_pkg.sv
// Shared configuration types for the layer weight loader: FSM state encoding,
// configuration word width and the counter-width helper.
package nn_cfg_pkg;

  localparam int CFG_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BIAS   = 2'd1,
    ST_WEIGHT = 2'd2,
    ST_DONE   = 2'd3
  } load_state_e;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_weight_loader_if.sv
// Parameter-word stream plus the shared neuron configuration bus.
// master = loader side, slave = host stream source / neuron layer side.
interface layer_weight_loader_if;
  import nn_cfg_pkg::*;

  logic [CFG_WORD_W-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  weightValid;
  logic                  biasValid;
  logic [CFG_WORD_W-1:0] weightValue;
  logic [CFG_WORD_W-1:0] biasValue;
  logic [CFG_WORD_W-1:0] config_layer_num;
  logic [CFG_WORD_W-1:0] config_neuron_num;

  modport master (
    input  s_data, s_valid,
    output s_ready, weightValid, biasValid, weightValue, biasValue,
           config_layer_num, config_neuron_num
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, weightValid, biasValid, weightValue, biasValue,
           config_layer_num, config_neuron_num
  );

endinterface

// File: rtl/layer_weight_loader_cfg_word_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that is
// high while the count sits at its terminal value MAX-1.
module cfg_word_counter #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(MAX - 1));

endmodule

// File: rtl/layer_weight_loader.sv
// Streams a layer's parameters into its neurons, one neuron at a time.
// Define BIAS_LOAD_EN to prefix each neuron record with a bias word.
module layer_weight_loader
  import nn_cfg_pkg::*;
#(
  parameter int layerNo    = 1,
  parameter int numNeurons = 30,
  parameter int numWeight  = 784,
  parameter int dataWidth  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  layer_weight_loader_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam int WCNT_W = cnt_w(numWeight);
  localparam int NCNT_W = cnt_w(numNeurons);

`ifdef BIAS_LOAD_EN
  localparam load_state_e ST_RECORD = ST_BIAS;
`else
  localparam load_state_e ST_RECORD = ST_WEIGHT;
`endif

  if (dataWidth < 1 || dataWidth > CFG_WORD_W) begin : g_width_check
    $error("layer_weight_loader: dataWidth must lie in 1..32");
  end

  load_state_e             r_state;
  load_state_e             w_next;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_acc_w;
  logic                    w_last_w;
  logic                    w_wtc;
  logic                    w_ntc;
  logic [WCNT_W-1:0]       w_wcnt_unused;
  logic [NCNT_W-1:0]       w_ncnt;
  logic                    r_wvalid;
  logic                    r_done;
  logic [CFG_WORD_W-1:0]   r_wvalue;
  logic [CFG_WORD_W-1:0]   r_layer;
  logic [CFG_WORD_W-1:0]   r_neuron;

  assign w_ready  = (r_state == ST_BIAS) || (r_state == ST_WEIGHT);
  assign w_accept = bus.s_valid && w_ready;
  assign w_acc_w  = w_accept && (r_state == ST_WEIGHT);
  assign w_last_w = w_acc_w && w_wtc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_RECORD;
`ifdef BIAS_LOAD_EN
      ST_BIAS:   if (w_accept) w_next = ST_WEIGHT;
`endif
      ST_WEIGHT: if (w_last_w) w_next = w_ntc ? ST_DONE : ST_RECORD;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  cfg_word_counter #(.MAX(numWeight), .W(WCNT_W)) u_weight_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr ((r_state == ST_IDLE) || w_last_w),
    .i_en  (w_acc_w),
    .o_cnt (w_wcnt_unused),
    .o_tc  (w_wtc)
  );

  cfg_word_counter #(.MAX(numNeurons), .W(NCNT_W)) u_neuron_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == ST_IDLE),
    .i_en  (w_last_w && !w_ntc),
    .o_cnt (w_ncnt),
    .o_tc  (w_ntc)
  );

  // Output stage: strobe, data and neuron index are captured on the same edge
  // so the index on the bus always belongs to the word being strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wvalid <= 1'b0;
      r_done   <= 1'b0;
      r_wvalue <= '0;
      r_layer  <= '0;
      r_neuron <= '0;
    end else begin
      r_wvalid <= w_acc_w;
      r_done   <= (r_state == ST_DONE);
      if (w_acc_w) r_wvalue <= bus.s_data;
      if ((r_state == ST_IDLE) && start) begin
        r_layer  <= CFG_WORD_W'(layerNo);
        r_neuron <= '0;
      end else if (w_accept) begin
        r_neuron <= CFG_WORD_W'(w_ncnt);
      end
    end
  end

`ifdef BIAS_LOAD_EN
  logic                  r_bvalid;
  logic [CFG_WORD_W-1:0] r_bvalue;
  logic                  w_acc_b;

  assign w_acc_b = w_accept && (r_state == ST_BIAS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bvalue <= '0;
    end else begin
      r_bvalid <= w_acc_b;
      if (w_acc_b) r_bvalue <= bus.s_data;
    end
  end

  assign bus.biasValid = r_bvalid;
  assign bus.biasValue = r_bvalue;
`else
  assign bus.biasValid = 1'b0;
  assign bus.biasValue = '0;
`endif

  assign bus.s_ready           = w_ready;
  assign bus.weightValid       = r_wvalid;
  assign bus.weightValue       = r_wvalue;
  assign bus.config_layer_num  = r_layer;
  assign bus.config_neuron_num = r_neuron;
  assign busy                  = (r_state != ST_IDLE);
  assign done                  = r_done;

endmodule

// File: tb/tb_layer_weight_loader.sv
// Bench for layer_weight_loader: random word streams and valid patterns checked
// cycle by cycle against a record-order model of the expected neuron bus.
module tb_layer_weight_loader;
  import nn_cfg_pkg::*;

  localparam int NN    = 2;
  localparam int NW    = 3;
  localparam int LAYER = 5;
`ifdef BIAS_LOAD_EN
  localparam int HASB = 1;
`else
  localparam int HASB = 0;
`endif
  localparam int PER   = NW + HASB;
  localparam int TOTAL = NN * PER;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  layer_weight_loader_if bus();

  layer_weight_loader #(
    .layerNo    (LAYER),
    .numNeurons (NN),
    .numWeight  (NW),
    .dataWidth  (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 streaming, 2 final word taken (done follows).
  int          phase;
  int          acc;
  int          strobe_cnt;
  int          done_cnt;
  logic [31:0] e_wval, e_bval, e_neuron, e_layer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input bit exp_wv, input bit exp_bv, input bit exp_done);
    check("weightValid", bus.weightValid, exp_wv);
    check("biasValid", bus.biasValid, exp_bv);
    check("weightValue", bus.weightValue, e_wval);
    check("biasValue", bus.biasValue, e_bval);
    check("config_neuron_num", bus.config_neuron_num, e_neuron);
    check("config_layer_num", bus.config_layer_num, e_layer);
    check("done", done, exp_done);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    phase = 0; acc = 0;
    e_wval = '0; e_bval = '0; e_neuron = '0; e_layer = '0;
    check_bus(1'b0, 1'b0, 1'b0);
    check("reset_s_ready", bus.s_ready, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
  endtask

  task automatic step(input bit sv, input bit st);
    logic [31:0] d;
    bit          acc_now, st_now, was_done, is_bias;
    int          k;
    d = $urandom;
    bus.s_data = d;
    bus.s_valid = sv;
    start = st;
    #1;
    check("s_ready", bus.s_ready, (phase == 1));
    check("busy", busy, (phase != 0));
    acc_now  = sv && (phase == 1);
    st_now   = st && (phase == 0);
    was_done = (phase == 2);
    k        = acc;
    is_bias  = (HASB == 1) && (k % PER == 0);
    @(posedge clk); #1;
    start = 1'b0;
    if (was_done) phase = 0;
    if (st_now) begin
      phase = 1; acc = 0; e_layer = LAYER; e_neuron = 0;
    end
    if (acc_now) begin
      e_neuron = k / PER;
      if (is_bias) e_bval = d;
      else         e_wval = d;
      acc++;
      if (acc == TOTAL) phase = 2;
    end
    check_bus(acc_now && !is_bias, acc_now && is_bias, was_done);
    if (bus.weightValid || bus.biasValid) strobe_cnt++;
    if (done) done_cnt++;
  endtask

  // mode 0: continuous valid, 1: valid toggles each cycle, 2: random valid
  task automatic run_load(input int mode, input int restart_at, input int rst_at);
    bit sv, st, restarted;
    strobe_cnt = 0;
    done_cnt   = 0;
    restarted  = 1'b0;
    step(1'b1, 1'b1);
    for (int c = 0; c < 200 && phase != 0; c++) begin
      if (rst_at >= 0 && acc == rst_at) begin
        do_reset();
        return;
      end
      sv = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(0, 1));
      st = (acc == restart_at) && !restarted;
      if (st) restarted = 1'b1;
      step(sv, st);
    end
    check("load_finished_busy", busy, 0);
    check("strobe_count", strobe_cnt, TOTAL);
    check("done_count", done_cnt, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    do_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    run_load(0, -1, -1);
    run_load(1, -1, -1);
    run_load(2, 4, -1);
    run_load(0, -1, 5);
    run_load(0, -1, -1);
    run_load(2, -1, -1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
